// File: rtl/tempsens_pkg.sv
// Shared definitions for the temperature sensor controller: register map,
// FSM state encoding, reset values and STATUS/CTRL bit positions.
package tempsens_pkg;

    localparam logic [11:0] ADDR_CTRL   = 12'h000;
    localparam logic [11:0] ADDR_WINDOW = 12'h004;
    localparam logic [11:0] ADDR_ENABLE = 12'h00C;
    localparam logic [11:0] ADDR_RESULT = 12'h010;
    localparam logic [11:0] ADDR_STATUS = 12'h014;

    localparam int WINDOW_RST = 1000;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_START  = 1;
    localparam int CTRL_ABORT  = 2;

    localparam int STAT_DONE = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_OVF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/tempsens_edge_sync.sv
// Brings the free-running sensor oscillator into clk_i: 2-FF synchronizer plus
// rising-edge pulse; a pin edge shows up as a one-cycle pulse two edges later.
module tempsens_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic [2:0] r_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], async_i};
        end
    end

    assign rise_o = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/tempsens_ctrl.sv
// Temperature sensor controller: register block, enable/settle/gate sequencer, osc edge counter.
// Build option TEMPSENS_AVG_EN: four gate windows per start, RESULT = accumulated sum >> 2.
module tempsens_ctrl
    import tempsens_pkg::*;
#(
    parameter int CntW      = 20,
    parameter int WinW      = 16,
    parameter int SettleCyc = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        re_i,
    input  logic        we_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o,
    output logic        error_o,
    output logic        sens_en_o,
    output logic        sens_sel_o,
    input  logic        sens_osc_i,
    output logic        done_irq_o
);

    localparam int SetW = $clog2(SettleCyc + 1);
    localparam int TmrW = (WinW > SetW) ? WinW : SetW;
    localparam int AccW = CntW + 2;

    state_e          r_state, w_state_nxt;
    logic [TmrW-1:0] r_tmr;
    logic [CntW-1:0] r_cnt, w_cnt_nxt, r_result, w_result_nxt;
    logic [WinW-1:0] r_window, w_window_wr;
    logic [31:0]     w_win_merge;
    logic            r_irq_en, r_enable, r_sel, r_done, r_ovf;
    logic            w_hit, w_wr, w_rd, w_wr_ctrl, w_wr_stat, w_busy, w_edge;
    logic            w_start, w_abort, w_done_go, w_settle_end, w_win_end;
    logic            w_gate_end, w_gate_inc, w_sat, w_last_win, w_unused;

    tempsens_edge_sync u_edge_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (sens_osc_i),
        .rise_o  (w_edge)
    );

    assign w_hit     = (addr_i == ADDR_CTRL)   || (addr_i == ADDR_WINDOW) ||
                       (addr_i == ADDR_ENABLE) || (addr_i == ADDR_RESULT) ||
                       (addr_i == ADDR_STATUS);
    assign error_o   = (re_i & we_i) | ((re_i | we_i) & ~w_hit);
    assign w_wr      = we_i & ~re_i & w_hit;
    assign w_rd      = re_i & ~we_i & w_hit;
    assign w_wr_ctrl = w_wr && (addr_i == ADDR_CTRL) && be_i[0];
    assign w_wr_stat = w_wr && (addr_i == ADDR_STATUS) && be_i[0];

    assign w_busy    = (r_state != ST_IDLE);
    assign w_start   = w_wr_ctrl & wdata_i[CTRL_START] & ~w_busy;
    assign w_abort   = w_wr_ctrl & wdata_i[CTRL_ABORT] & w_busy;
    assign w_done_go = (r_state == ST_DONE) & ~w_abort;

    assign w_settle_end = (r_tmr == TmrW'(SettleCyc - 1));
    assign w_win_end    = (r_tmr == TmrW'(r_window) - TmrW'(1));
    assign w_gate_end   = (r_state == ST_GATE) & w_win_end;
    assign w_gate_inc   = (r_state == ST_GATE) & w_edge;
    assign w_sat        = &r_cnt;
    assign w_cnt_nxt    = (w_gate_inc & ~w_sat) ? r_cnt + CntW'(1) : r_cnt;

    assign sens_en_o  = w_busy | r_enable;
    assign sens_sel_o = r_sel;
    assign done_irq_o = r_done & r_irq_en;

    // Byte-merge into the current WINDOW; a zero length would never close the gate.
    always_comb begin
        w_win_merge = 32'(r_window);
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) w_win_merge[8*b +: 8] = wdata_i[8*b +: 8];
        end
        w_window_wr = w_win_merge[WinW-1:0];
        if (w_window_wr == '0) w_window_wr = WinW'(1);
    end
    assign w_unused = ^w_win_merge[31:WinW];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_start) w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (w_settle_end) w_state_nxt = ST_GATE;
            ST_GATE:   if (w_win_end && w_last_win) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state || w_gate_end) r_tmr <= '0;
            else if (w_busy)                          r_tmr <= r_tmr + TmrW'(1);
            if (w_start || (w_gate_end && !w_last_win)) r_cnt <= '0;
            else                                        r_cnt <= w_cnt_nxt;
        end
    end

`ifdef TEMPSENS_AVG_EN
    logic [1:0]      r_win_idx;
    logic [AccW-1:0] r_acc;
    logic            w_avg_unused;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_win_idx <= '0;
            r_acc     <= '0;
        end else if (w_start) begin
            r_win_idx <= '0;
            r_acc     <= '0;
        end else if (w_gate_end) begin
            r_win_idx <= r_win_idx + 2'd1;
            r_acc     <= r_acc + AccW'(w_cnt_nxt);
        end
    end

    assign w_last_win   = (r_win_idx == 2'd3);
    assign w_result_nxt = r_acc[AccW-1:2];
    assign w_avg_unused = ^r_acc[1:0];
`else
    assign w_last_win   = 1'b1;
    assign w_result_nxt = r_cnt;
`endif

    // Hardware set beats a software clear landing in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_start)                             r_done <= 1'b0;
            else if (w_done_go)                      r_done <= 1'b1;
            else if (w_wr_stat && wdata_i[STAT_DONE]) r_done <= 1'b0;

            if (w_start)                             r_ovf <= 1'b0;
            else if (w_gate_inc && w_sat)            r_ovf <= 1'b1;
            else if (w_wr_stat && wdata_i[STAT_OVF])  r_ovf <= 1'b0;

            if (w_start)        r_result <= '0;
            else if (w_done_go) r_result <= w_result_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq_en <= 1'b0;
            r_window <= WinW'(WINDOW_RST);
            r_enable <= 1'b0;
            r_sel    <= 1'b0;
        end else if (w_wr) begin
            if (w_wr_ctrl)                                 r_irq_en <= wdata_i[CTRL_IRQ_EN];
            if (addr_i == ADDR_WINDOW)                     r_window <= w_window_wr;
            if (addr_i == ADDR_ENABLE && be_i[0])          r_enable <= wdata_i[0];
            if (addr_i == ADDR_RESULT && be_i[0] && !w_busy) r_sel  <= wdata_i[0];
        end
    end

    always_comb begin
        rdata_o = '0;
        if (w_rd) begin
            case (addr_i)
                ADDR_CTRL:   rdata_o = {31'd0, r_irq_en};
                ADDR_WINDOW: rdata_o = 32'(r_window);
                ADDR_ENABLE: rdata_o = {31'd0, r_enable};
                ADDR_RESULT: rdata_o = 32'(r_result);
                ADDR_STATUS: rdata_o = {29'd0, r_ovf, w_busy, r_done};
                default:     rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_tempsens_ctrl.sv
// Randomized self-checking bench for tempsens_ctrl against a rate-based reference model.
`timescale 1ns/1ps
module tb_tempsens_ctrl;

    localparam int S    = 16;
    localparam int CNTW = 8;
`ifdef TEMPSENS_AVG_EN
    localparam int NWIN = 4;
`else
    localparam int NWIN = 1;
`endif
    localparam logic [11:0] A_CTRL   = 12'h000;
    localparam logic [11:0] A_WINDOW = 12'h004;
    localparam logic [11:0] A_ENABLE = 12'h00C;
    localparam logic [11:0] A_SELECT = 12'h010;
    localparam logic [11:0] A_STATUS = 12'h014;

    logic        clk, rst_n, re, we, sens_en, sens_sel, osc, irq, err;
    logic [11:0] addr;
    logic [31:0] wdata, rdata;
    logic [3:0]  be;

    int n_cmp = 0;
    int n_err = 0;
    int osc_per = 10;
    int osc_mode = 0;
    logic wr_err;

    tempsens_ctrl #(.CntW(CNTW), .WinW(16), .SettleCyc(S)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .re_i       (re),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .be_i       (be),
        .rdata_o    (rdata),
        .error_o    (err),
        .sens_en_o  (sens_en),
        .sens_sel_o (sens_sel),
        .sens_osc_i (osc),
        .done_irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator: mode 0 stuck low, 1 free running, 2 stuck high.
    initial begin
        osc = 1'b0;
        forever begin
            if (osc_mode == 1) begin
                #(osc_per * 5);
                osc = ~osc;
            end else begin
                #1;
                osc = (osc_mode == 2);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input longint obs, input longint exp, input int tol = 0);
        longint diff;
        n_cmp++;
        diff = obs - exp;
        if (diff > tol || diff < -tol) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (tolerance %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b = 4'hF);
        addr = a; wdata = d; be = b; we = 1'b1;
        #1 wr_err = err;
        @(posedge clk);
        #1;
        we = 1'b0; wdata = '0; be = '0; addr = '0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic e);
        addr = a; re = 1'b1;
        #1;
        d = rdata;
        e = err;
        re = 1'b0; addr = '0;
        #1;
    endtask

    task automatic start_meas(input int w, input bit irq_en);
        wr(A_WINDOW, 32'(w));
        wr(A_CTRL, {30'd0, 1'b1, irq_en});
        chk("sens_en_busy", sens_en, 1);
    endtask

    // Cycles counted from the start write edge; skip = cycles already spent.
    task automatic wait_done(input int w, input bit irq_en, input int skip, output int res);
        logic [31:0] d;
        logic        e;
        int          n;
        bit          seen;
        logic        pre_irq;
        n = skip; seen = 0; pre_irq = 1'b0; d = '0;
        while (!seen && n <= S + NWIN * w + 20) begin
            rd(A_STATUS, d, e);
            if (d[0]) seen = 1;
            else begin
                pre_irq = irq;
                tick();
                n++;
            end
        end
        chk("latency", n, S + NWIN * w + 1);
        chk("irq_before_done", pre_irq, 0);
        chk("irq_with_done", irq, irq_en);
        chk("busy_after_done", d[1], 0);
        rd(A_SELECT, d, e);
        res = int'(d);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          res, p, w;
        bit          sel, ie, en;

        rst_n = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_error", err, 0);
        chk("rst_sens_en", sens_en, 0);
        chk("rst_sens_sel", sens_sel, 0);
        chk("rst_irq", irq, 0);
        rst_n = 1'b1;
        tick();
        rd(A_ENABLE, d, e); chk("rst_enable", d, 0);
        rd(A_SELECT, d, e); chk("rst_result", d, 0);
        rd(A_STATUS, d, e); chk("rst_status", d, 0);
        rd(A_WINDOW, d, e); chk("rst_window", d, 1000);
        rd(A_CTRL, d, e);   chk("rst_ctrl", d, 0);

        // Nominal measurement: period 10, window 1000.
        osc_per = 10; osc_mode = 1;
        tick(5);
        start_meas(1000, 0);
        wait_done(1000, 0, 0, res);
        chk("result_p10", res, 100, 1);

        // Sensor select and interrupt path.
        wr(A_SELECT, 32'd1);
        chk("sel_set", sens_sel, 1);
        start_meas(200, 1);
        wait_done(200, 1, 0, res);
        chk("result_w200", res, 20, 1);
        wr(A_STATUS, 32'd1);
        chk("irq_cleared", irq, 0);
        rd(A_STATUS, d, e); chk("done_cleared", d[0], 0);

        // Select write and second start while busy are ignored.
        start_meas(100, 1);
        wr(A_SELECT, 32'd0);
        chk("sel_busy_noerr", wr_err, 0);
        wr(A_CTRL, 32'h3);
        chk("sel_busy_kept", sens_sel, 1);
        wait_done(100, 1, 2, res);
        chk("result_w100", res, 10, 1);
        wr(A_STATUS, 32'd1);

        // Oscillator stuck high yields no edges.
        osc_mode = 2;
        tick(20);
        start_meas(3, 0);
        wait_done(3, 0, 0, res);
        chk("result_stuck", res, 0);

        // WINDOW zero coercion and byte enables.
        wr(A_WINDOW, 32'd0);
        rd(A_WINDOW, d, e); chk("window_zero", d, 1);
        wr(A_WINDOW, 32'h0000_1234, 4'b0001);
        rd(A_WINDOW, d, e); chk("window_be0", d, 32'h34);
        wr(A_WINDOW, 32'h0000_5600, 4'b0010);
        rd(A_WINDOW, d, e); chk("window_be1", d, 32'h5634);
        wr(A_WINDOW, 32'hFFFF_0000, 4'b1100);
        rd(A_WINDOW, d, e); chk("window_be_hi", d, 32'h5634);

        // Access errors.
        rd(12'h020, d, e);
        chk("err_rd_flag", e, 1);
        chk("err_rd_data", d, 0);
        rd(12'h008, d, e); chk("err_gap", e, 1);
        wr(12'h020, 32'hFFFF_FFFF);
        chk("err_wr_flag", wr_err, 1);
        addr = A_WINDOW; wdata = 32'd7; be = 4'hF; re = 1'b1; we = 1'b1;
        #1 chk("err_rw_flag", err, 1);
        tick();
        re = 1'b0; we = 1'b0;
        rd(A_WINDOW, d, e); chk("err_rw_noeffect", d, 32'h5634);

        // Abort during GATE.
        osc_per = 10; osc_mode = 1;
        tick(5);
        start_meas(1000, 0);
        tick(S + 100);
        wr(A_CTRL, 32'h4);
        rd(A_STATUS, d, e);
        chk("abort_busy", d[1], 0);
        chk("abort_done", d[0], 0);
        chk("abort_sens_en", sens_en, 0);
        tick(1100);
        rd(A_STATUS, d, e); chk("abort_stays_idle", d[0], 0);

        // Saturation: ~300 edges per window into an 8-bit counter.
        osc_per = 4;
        tick(20);
        start_meas(1200, 0);
        wait_done(1200, 0, 0, res);
        chk("result_sat", res, 255);
        rd(A_STATUS, d, e); chk("ovf_set", d[2], 1);
        wr(A_STATUS, 32'd4);
        rd(A_STATUS, d, e);
        chk("ovf_cleared", d[2], 0);
        chk("done_kept", d[0], 1);

        // Randomized measurements against the edge-rate model.
        for (int it = 0; it < 6; it++) begin
            p   = $urandom_range(4, 16);
            w   = $urandom_range(40, 400);
            sel = 1'($urandom_range(0, 1));
            ie  = 1'($urandom_range(0, 1));
            en  = 1'($urandom_range(0, 1));
            osc_per = p;
            tick(20);
            wr(A_SELECT, {31'd0, sel});
            wr(A_ENABLE, {31'd0, en});
            start_meas(w, ie);
            wait_done(w, ie, 0, res);
            chk("rand_result", res, w / p, 1);
            chk("rand_sel", sens_sel, sel);
            chk("rand_sens_en_idle", sens_en, en);
            rd(A_STATUS, d, e); chk("rand_ovf", d[2], 0);
            wr(A_STATUS, 32'd1);
            chk("rand_irq_clr", irq, 0);
        end

        // Reset in the middle of a measurement.
        wr(A_ENABLE, 32'd0);
        start_meas(500, 1);
        tick(30);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sens_en", sens_en, 0);
        chk("mid_rst_sel", sens_sel, 0);
        chk("mid_rst_irq", irq, 0);
        rd(A_STATUS, d, e); chk("mid_rst_status", d, 0);
        rd(A_WINDOW, d, e); chk("mid_rst_window", d, 1000);
        tick(2);
        rst_n = 1'b1;
        tick(600);
        rd(A_STATUS, d, e); chk("post_rst_idle", d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tempsens_ctrl.md
# tempsens_ctrl

Register-mapped controller for one on-die temperature sensor, sitting directly downstream of the TL-UL-to-register adapter on a tempsensor slot of the peripheral crossbar. It consumes the adapter's simple read/write strobe interface. It sequences sensor enable, settling and a fixed gate window, and counts sensor-oscillator edges in that window. The count is exposed as the temperature code, with done status and an interrupt.

## Interface
Parameters:
- `CntW`, default 20: result/edge-counter width.
- `WinW`, default 16: gate-window length register width.
- `SettleCyc`, default 16: clk_i cycles between sensor enable and gate open.

Ports:
- `clk_i` in 1: single system clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `re_i` in 1: register read strobe from adapter.
- `we_i` in 1: register write strobe from adapter.
- `addr_i` in 12: byte address, word aligned.
- `wdata_i` in 32: write data.
- `be_i` in 4: byte enables.
- `rdata_o` out 32: read data, valid in the same cycle as `re_i`.
- `error_o` out 1: access error, same cycle as `re_i`/`we_i`.
- `sens_en_o` out 1: sensor power/enable.
- `sens_sel_o` out 1: sensor core select (0 = LC1, 1 = LC2).
- `sens_osc_i` in 1: sensor oscillator, asynchronous to `clk_i`.
- `done_irq_o` out 1: level interrupt, equals `STATUS.done & IRQ_EN`.

## Operation
Register map, 32-bit, byte-enable honoured on writable bytes:
- 0x00 CTRL, rw. Bit0 `irq_en`. Bit1 `start` (write-1 pulse, reads 0). Bit2 `abort` (write-1 pulse, reads 0).
- 0x04 WINDOW, rw. Bits[WinW-1:0] gate length in clk_i cycles. Reset 1000. A write of 0 is stored as 1.
- 0x0C ENABLE, rw. Bit0 forces `sens_en_o` high while IDLE (continuous mode).
- 0x10 SELECT/RESULT. A write sets bit0 `sens_sel_o`. A read returns the RESULT count, zero-extended.
- 0x14 STATUS. Bit0 `done`, bit1 `busy`, bit2 `ovf`. A write-1 to bit0 or bit2 clears that bit.
- Any other offset: `error_o`=1, reads 0, writes ignored.
- Simultaneous `re_i` and `we_i`: `error_o`=1, no effect.

FSM states:
- IDLE. `start` moves to SETTLE, clears `done`/`ovf`/RESULT and the edge counter.
- SETTLE. `sens_en_o`=1 for `SettleCyc` cycles, then moves to GATE.
- GATE. Counts synchronized `sens_osc_i` rising edges for WINDOW cycles, then moves to DONE.
- DONE. One cycle: latches the counter into RESULT, sets `done`, moves to IDLE.
- `busy`=1 in SETTLE, GATE and DONE.
- `start` while busy is ignored.
- `abort` in any busy state returns to IDLE. RESULT and `done` stay unchanged.
- The counter saturates at 2^CntW-1 and sets `ovf`.
- `sens_sel_o` writes while busy are ignored, with no error.
- A STATUS clear that coincides with the DONE cycle: the set wins.

## Timing
- Reset values: `rdata_o`=0, `error_o`=0, `sens_en_o`=0, `sens_sel_o`=0, `done_irq_o`=0. All registers reset to 0 except WINDOW=1000. FSM starts in IDLE.
- Register writes take effect on the clock edge where `we_i`=1.
- Reads are combinational from flops.
- `sens_osc_i` passes through a 2-FF synchronizer plus an edge detector. Each counted edge lands 3 cycles after the pin edge. Sensor frequency must be below clk_i/2.
- Latency: `start` write edge, then SettleCyc+WINDOW+1 cycles until `done`=1. `done_irq_o` rises in the same cycle.
- Asserting `rst_ni` mid-measurement returns everything to reset values at once.

## Configuration
- `TEMPSENS_AVG_EN` defined: each `start` runs four back-to-back GATE windows with a single SETTLE. RESULT is the 22-bit-accumulated sum shifted right by 2, truncated. `ovf` sets if any window saturates.
- Not defined: single window, as described above.

## Structure
- `tempsens_pkg` holds:
  - register offset localparams;
  - the FSM state enum;
  - the WINDOW reset value;
  - the STATUS bit indices.
- Sub-module `tempsens_edge_sync` contains the 2-FF synchronizer and rising-edge pulse generator, with async active-low reset.

## Test plan
- Reset, then read 0x0C, 0x10, 0x14 → 0, 0, 0. Read 0x04 → 1000. `sens_en_o`=0.
- Osc period 10 clk, WINDOW=1000, `start` → `done` after 1017 cycles. RESULT=100±1. `busy`=0.
- Write SELECT=1, `irq_en`=1, `start` → `sens_sel_o`=1. `done_irq_o` rises with `done`. Write STATUS=1 → `done_irq_o`=0.
- WINDOW=3, osc stuck high → RESULT=0. WINDOW=0 write → readback 1.
- Abort during GATE → `busy`=0 next cycle, previous RESULT retained. Read 0x20 → `error_o`=1, rdata 0.
- CntW=4 build, osc period 4, WINDOW=200 → RESULT=15, `ovf`=1. With `TEMPSENS_AVG_EN` and the default build, osc period 10 → RESULT=100±1 after SettleCyc+4·WINDOW+1 cycles.
